// File: rtl/chunked_add_ctrl.sv
// chunked_add_ctrl
//   Multi-cycle adder/subtractor that reuses one CHUNK-bit ripple adder over
//   NCH = WIDTH/CHUNK cycles, LSB chunk first, with the inter-chunk carry held
//   in a register. Subtraction is a + ~b + 1.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request a new operation (ignored while busy)
//   op_sub    0: a + b + carry_In, 1: a - b
//   a, b      WIDTH-bit operands, sampled with start
//   carry_In  carry into bit 0 for add; ignored for subtract
//   busy      operation in progress
//   done      one-cycle pulse, result valid
//   sum       result register (updated only on completion)
//   carry_Out carry out of MSB (for subtract: 1 = no borrow)
//   overflow  signed two's-complement overflow of the result
module chunked_add_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_In,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_Out,
    output logic             overflow
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;      // already inverted for subtract
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic [CHUNK:0]   slice_add;
    logic             last;
    logic             accept;

    // Shared slice adder; work_nxt is the working register with the current
    // slice merged in, so the final load of sum sees the last slice too.
    always_comb begin
        slice_add = {1'b0, op_a[idx*CHUNK +: CHUNK]}
                  + {1'b0, op_b[idx*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_r};
        work_nxt = work;
        work_nxt[idx*CHUNK +: CHUNK] = slice_add[CHUNK-1:0];
        last = (idx == IDX_W'(NCH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            work      <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_Out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= op_sub ? ~b : b;
            carry_r <= op_sub ? 1'b1 : carry_In;
            idx     <= '0;
        end else if (state == RUN) begin
            work    <= work_nxt;
            carry_r <= slice_add[CHUNK];
            idx     <= idx + 1'b1;
            if (last) begin
                sum       <= work_nxt;
                carry_Out <= slice_add[CHUNK];
                overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                             (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
            end
        end
    end

endmodule
